// File: rtl/sdram_rr_arb_if.sv
// Port A / port B / core request-response bundle for the sdram round-robin arbiter.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface sdram_rr_arb_if;
   logic [3:0]  portA_wr_i;
   logic        portA_rd_i;
   logic [31:0] portA_addr_i;
   logic [31:0] portA_write_data_i;
   logic        portA_accept_o;
   logic        portA_ack_o;
   logic        portA_error_o;
   logic [31:0] portA_read_data_o;
   logic [3:0]  portB_wr_i;
   logic        portB_rd_i;
   logic [31:0] portB_addr_i;
   logic [31:0] portB_write_data_i;
   logic        portB_accept_o;
   logic        portB_ack_o;
   logic        portB_error_o;
   logic [31:0] portB_read_data_o;
   logic [3:0]  core_wr_o;
   logic        core_rd_o;
   logic [31:0] core_addr_o;
   logic [31:0] core_write_data_o;
   logic        core_accept_i;
   logic        core_ack_i;
   logic        core_error_i;
   logic [31:0] core_read_data_i;

   modport slave (
      input  portA_wr_i, portA_rd_i, portA_addr_i, portA_write_data_i,
      output portA_accept_o, portA_ack_o, portA_error_o, portA_read_data_o,
      input  portB_wr_i, portB_rd_i, portB_addr_i, portB_write_data_i,
      output portB_accept_o, portB_ack_o, portB_error_o, portB_read_data_o,
      output core_wr_o, core_rd_o, core_addr_o, core_write_data_o,
      input  core_accept_i, core_ack_i, core_error_i, core_read_data_i
   );

   modport master (
      output portA_wr_i, portA_rd_i, portA_addr_i, portA_write_data_i,
      input  portA_accept_o, portA_ack_o, portA_error_o, portA_read_data_o,
      output portB_wr_i, portB_rd_i, portB_addr_i, portB_write_data_i,
      input  portB_accept_o, portB_ack_o, portB_error_o, portB_read_data_o,
      input  core_wr_o, core_rd_o, core_addr_o, core_write_data_o,
      output core_accept_i, core_ack_i, core_error_i, core_read_data_i
   );
endinterface

// File: rtl/sdram_rr_arb.sv
// Two-port round-robin arbiter in front of the sdram32 core request port.
// An in-order tag FIFO steers each core response back to the port that issued the request.
module sdram_rr_arb #(
   parameter int OUTSTANDING = 4
) (
   input logic           ACLK,
   input logic           ARSTN,
   sdram_rr_arb_if.slave bus
);
   localparam int PW = $clog2(OUTSTANDING);
   localparam int CW = PW + 1;

   logic                   last_q;
   logic                   lock_q;
   logic                   lock_port_q;
   logic [CW-1:0]          count_q;
   logic [PW-1:0]          wptr_q;
   logic [PW-1:0]          rptr_q;
   logic [OUTSTANDING-1:0] tag_q;

   logic req_a, req_b, sel, sel_req;
   logic full, active, fire, pop, head;

   assign req_a = (|bus.portA_wr_i) | bus.portA_rd_i;
   assign req_b = (|bus.portB_wr_i) | bus.portB_rd_i;

   // A locked port keeps the grant until the core takes its request.
   always_comb begin
      sel = 1'b0;
      if (lock_q)
         sel = lock_port_q;
      else if (req_a && req_b)
         sel = ~last_q;
      else if (req_b)
         sel = 1'b1;
   end

   assign sel_req = sel ? req_b : req_a;
   assign full    = (count_q == CW'(OUTSTANDING));
   assign active  = ARSTN & sel_req & ~full;
   assign fire    = active & bus.core_accept_i;
   assign pop     = ARSTN & bus.core_ack_i & (count_q != '0);
   assign head    = tag_q[rptr_q];

   assign bus.core_wr_o = active ? (sel ? bus.portB_wr_i : bus.portA_wr_i) : 4'h0;
   assign bus.core_rd_o = active & (sel ? bus.portB_rd_i : bus.portA_rd_i);
   assign bus.core_addr_o = sel ? bus.portB_addr_i : bus.portA_addr_i;
   assign bus.core_write_data_o = sel ? bus.portB_write_data_i
                                      : bus.portA_write_data_i;

   assign bus.portA_accept_o    = fire & ~sel;
   assign bus.portB_accept_o    = fire & sel;
   assign bus.portA_ack_o       = pop & ~head;
   assign bus.portB_ack_o       = pop & head;
   assign bus.portA_error_o     = pop & ~head & bus.core_error_i;
   assign bus.portB_error_o     = pop & head & bus.core_error_i;
   assign bus.portA_read_data_o = bus.core_read_data_i;
   assign bus.portB_read_data_o = bus.core_read_data_i;

   always_ff @(posedge ACLK or negedge ARSTN) begin
      if (!ARSTN) begin
         last_q      <= 1'b1;
         lock_q      <= 1'b0;
         lock_port_q <= 1'b0;
         count_q     <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         tag_q       <= '0;
      end else begin
         if (fire) begin
            tag_q[wptr_q] <= sel;
            wptr_q        <= wptr_q + PW'(1);
            last_q        <= sel;
         end
         if (pop)
            rptr_q <= rptr_q + PW'(1);
         count_q <= count_q + CW'(fire) - CW'(pop);
         // A full-gated request is not presented, so the lock holds its state.
         if (active) begin
            lock_q      <= ~bus.core_accept_i;
            lock_port_q <= sel;
         end
      end
   end
endmodule

// File: tb/tb_sdram_rr_arb.sv
// Directed table-driven bench for sdram_rr_arb with OUTSTANDING = 4.
// It adds hand-written sequences for reset behaviour.
module tb_sdram_rr_arb;
   typedef struct {
      logic [3:0]  aw;
      logic        ar;
      logic [31:0] aa;
      logic [3:0]  bw;
      logic        br;
      logic [31:0] ba;
      logic        cacc;
      logic        cack;
      logic        cerr;
      logic [31:0] rdat;
      logic [3:0]  ewr;
      logic        erd;
      logic [31:0] eaddr;
      logic        chka;
      logic [5:0]  eh;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   nvec = 0;
   int   nbad = 0;
   vec_t tbl[30];

   sdram_rr_arb_if bus();

   sdram_rr_arb #(.OUTSTANDING(4)) dut (
      .ACLK  (clk),
      .ARSTN (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      logic [3:0] aw, logic ar, logic [31:0] aa,
      logic [3:0] bw, logic br, logic [31:0] ba,
      logic cacc, logic cack, logic cerr, logic [31:0] rdat,
      logic [3:0] ewr, logic erd, logic [31:0] eaddr, logic chka,
      logic [5:0] eh);
      vec_t v;
      v.aw = aw; v.ar = ar; v.aa = aa;
      v.bw = bw; v.br = br; v.ba = ba;
      v.cacc = cacc; v.cack = cack; v.cerr = cerr; v.rdat = rdat;
      v.ewr = ewr; v.erd = erd; v.eaddr = eaddr; v.chka = chka;
      v.eh = eh;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.portA_wr_i = v.aw;
      bus.portA_rd_i = v.ar;
      bus.portA_addr_i = v.aa;
      bus.portA_write_data_i = v.aa ^ 32'h5A5A_0000;
      bus.portB_wr_i = v.bw;
      bus.portB_rd_i = v.br;
      bus.portB_addr_i = v.ba;
      bus.portB_write_data_i = v.ba ^ 32'hA5A5_0000;
      bus.core_accept_i = v.cacc;
      bus.core_ack_i = v.cack;
      bus.core_error_i = v.cerr;
      bus.core_read_data_i = v.rdat;
   endtask

   task automatic check(input vec_t v, input string nm);
      logic [5:0] gh;
      logic       bad;
      gh = {bus.portA_accept_o, bus.portB_accept_o,
            bus.portA_ack_o, bus.portB_ack_o,
            bus.portA_error_o, bus.portB_error_o};
      bad = (gh !== v.eh) || (bus.core_wr_o !== v.ewr) ||
            (bus.core_rd_o !== v.erd) ||
            (v.chka && (bus.core_addr_o !== v.eaddr)) ||
            (bus.portA_read_data_o !== v.rdat) ||
            (bus.portB_read_data_o !== v.rdat);
      nvec++;
      if (bad) begin
         nbad++;
         $display("FAIL %s: got acc/ack/err=%b wr=%h rd=%b addr=%h rdA=%h rdB=%h; need %b wr=%h rd=%b addr=%h(chk %b) rdata=%h",
                  nm, gh, bus.core_wr_o, bus.core_rd_o, bus.core_addr_o,
                  bus.portA_read_data_o, bus.portB_read_data_o,
                  v.eh, v.ewr, v.erd, v.eaddr, v.chka, v.rdat);
      end
   endtask

   task automatic apply(input vec_t v, input string nm);
      @(negedge clk);
      drive(v);
      #2;
      check(v, nm);
   endtask

   initial begin
      vec_t z;
      // solo read by A, acked three cycles later
      tbl[0]  = mk(0,1,'h100, 0,0,0, 1,0,0,0,            0,1,'h100,1, 6'b100000);
      tbl[1]  = mk(0,0,0,     0,0,0, 0,0,0,0,            0,0,0,0,     6'b000000);
      tbl[2]  = mk(0,0,0,     0,0,0, 0,0,0,0,            0,0,0,0,     6'b000000);
      tbl[3]  = mk(0,0,0,     0,0,0, 0,1,0,'hDEADBEEF,   0,0,0,0,     6'b001000);
      // B write acked with error, then a stray ack
      tbl[4]  = mk(0,0,0, 'hF,0,'h400, 1,0,0,0,          'hF,0,'h400,1, 6'b010000);
      tbl[5]  = mk(0,0,0,     0,0,0, 0,1,1,'h0000BAD0,   0,0,0,0,     6'b000101);
      tbl[6]  = mk(0,0,0,     0,0,0, 0,1,0,'h00005555,   0,0,0,0,     6'b000000);
      // contention with the core always accepting: A,B,A,B fills the FIFO
      tbl[7]  = mk(0,1,'h200, 0,1,'h300, 1,0,0,0,        0,1,'h200,1, 6'b100000);
      tbl[8]  = mk(0,1,'h200, 0,1,'h300, 1,0,0,0,        0,1,'h300,1, 6'b010000);
      tbl[9]  = mk(0,1,'h200, 0,1,'h300, 1,0,0,0,        0,1,'h200,1, 6'b100000);
      tbl[10] = mk(0,1,'h200, 0,1,'h300, 1,0,0,0,        0,1,'h300,1, 6'b010000);
      // full: gated, a pop does not release the gate in the same cycle
      tbl[11] = mk(0,1,'h500, 0,0,0, 1,0,0,0,            0,0,'h500,1, 6'b000000);
      tbl[12] = mk(0,1,'h500, 0,0,0, 1,1,0,'h1111,       0,0,'h500,1, 6'b001000);
      tbl[13] = mk(0,1,'h500, 0,0,0, 1,1,0,'h2222,       0,1,'h500,1, 6'b100100);
      tbl[14] = mk(0,0,0,     0,0,0, 0,1,0,'h3333,       0,0,0,0,     6'b001000);
      tbl[15] = mk(0,0,0,     0,0,0, 0,1,0,'h4444,       0,0,0,0,     6'b000100);
      tbl[16] = mk(0,0,0,     0,0,0, 0,1,0,'h5555,       0,0,0,0,     6'b001000);
      // lock: B held for 5 cycles while A competes
      tbl[17] = mk(0,0,0, 'h3,0,'h800, 1,0,0,0,          'h3,0,'h800,1, 6'b010000);
      tbl[18] = mk(0,0,0,     0,1,'h600, 0,0,0,0,        0,1,'h600,1, 6'b000000);
      tbl[19] = mk(0,1,'h700, 0,1,'h600, 0,0,0,0,        0,1,'h600,1, 6'b000000);
      tbl[20] = mk(0,1,'h700, 0,1,'h600, 0,0,0,0,        0,1,'h600,1, 6'b000000);
      tbl[21] = mk(0,1,'h700, 0,1,'h600, 0,0,0,0,        0,1,'h600,1, 6'b000000);
      tbl[22] = mk(0,1,'h700, 0,1,'h600, 0,0,0,0,        0,1,'h600,1, 6'b000000);
      tbl[23] = mk(0,1,'h700, 0,1,'h600, 1,0,0,0,        0,1,'h600,1, 6'b010000);
      tbl[24] = mk(0,1,'h700, 0,0,0, 1,0,0,0,            0,1,'h700,1, 6'b100000);
      tbl[25] = mk(0,0,0,     0,0,0, 0,1,0,'hA1,         0,0,0,0,     6'b000100);
      tbl[26] = mk(0,0,0,     0,0,0, 0,1,0,'hA2,         0,0,0,0,     6'b000100);
      tbl[27] = mk(0,0,0,     0,0,0, 0,1,0,'hA3,         0,0,0,0,     6'b001000);
      // two outstanding before the reset sequence
      tbl[28] = mk(0,1,'h900, 0,0,0, 1,0,0,0,            0,1,'h900,1, 6'b100000);
      tbl[29] = mk(0,0,0,     0,1,'hA00, 1,0,0,0,        0,1,'hA00,1, 6'b010000);

      // outputs held quiet during power-on reset
      drive(mk(0,1,'h100, 0,1,'h200, 1,1,1,'h77, 0,0,0,0, 0));
      #2;
      check(mk(0,1,'h100, 0,1,'h200, 1,1,1,'h77, 0,0,0,0, 0), "por");
      @(negedge clk);
      z = mk(0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0);
      drive(z);
      rst_n = 1'b1;

      for (int i = 0; i < 30; i++)
         apply(tbl[i], $sformatf("v%0d", i));

      // asynchronous reset with two requests outstanding
      @(negedge clk);
      drive(mk(0,1,'hB00, 0,1,'hC00, 1,1,0,'h99, 0,0,0,0, 0));
      #1;
      rst_n = 1'b0;
      #1;
      check(mk(0,1,'hB00, 0,1,'hC00, 1,1,0,'h99, 0,0,0,0, 0), "rst_async");
      @(negedge clk);
      drive(z);
      rst_n = 1'b1;
      apply(mk(0,0,0, 0,0,0, 0,1,0,'hC1, 0,0,0,0, 0), "rst_drop0");
      apply(mk(0,0,0, 0,0,0, 0,1,0,'hC2, 0,0,0,0, 0), "rst_drop1");
      apply(mk(0,1,'hB00, 0,1,'hC00, 1,0,0,0, 0,1,'hB00,1, 6'b100000), "rst_grantA");
      apply(mk(0,1,'hB00, 0,1,'hC00, 1,0,0,0, 0,1,'hC00,1, 6'b010000), "rst_grantB");
      apply(mk(0,0,0, 0,0,0, 0,1,0,'hD1, 0,0,0,0, 6'b001000), "rst_ackA");
      apply(mk(0,0,0, 0,0,0, 0,1,0,'hD2, 0,0,0,0, 6'b000100), "rst_ackB");
      apply(mk(0,0,0, 0,0,0, 0,1,0,'hD3, 0,0,0,0, 6'b000000), "rst_stray");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule

// File: doc/sdram_rr_arb.md
# sdram_rr_arb

Two-port round-robin request arbiter that sits directly upstream of the `sdram32` core input port. It merges a direct-access port (A) and an AXI-bridge port (B) onto the single core request interface. It records the issuing port of every accepted request in an in-order tag FIFO, and returns each core ack, error and read data to the port that issued the request.

## Interface
- `OUTSTANDING`, default 4: tag FIFO depth, which is the maximum number of accepted-but-unacked core requests. Power of two, 2..16.
- `ACLK` in 1: clock, rising edge.
- `ARSTN` in 1: asynchronous active-low reset.
- `portX_wr_i` in 4 (X = A, B): byte write strobes. Nonzero means a write request.
- `portX_rd_i` in 1: read request.
- `portX_addr_i` in 32: byte address.
- `portX_write_data_i` in 32: write data.
- `portX_accept_o` out 1: request accepted this cycle.
- `portX_ack_o` out 1: response for this port's oldest outstanding request.
- `portX_error_o` out 1: error qualifier for `portX_ack_o`.
- `portX_read_data_o` out 32: read data, valid with `portX_ack_o`.
- `core_wr_o` out 4, `core_rd_o` out 1, `core_addr_o` out 32, `core_write_data_o` out 32: merged request to the core.
- `core_accept_i` in 1, `core_ack_i` in 1, `core_error_i` in 1, `core_read_data_i` in 32: core handshake and response.

## Operation
- **Request validity.** A port requests when `wr != 0` or `rd = 1`. The port holds all request fields stable until it sees `accept`. `wr != 0` together with `rd = 1` is illegal; the arbiter forwards it unchanged.
- **Selection.**
  - The `last` register (0 = A, 1 = B) resets to 1, so A wins first.
  - When only one port requests, that port is selected.
  - When both request, the port other than `last` is selected.
- **Lock.**
  - When the selected request is driven to the core and not accepted, `lock` is set and `lock_port` holds the selection.
  - While `lock` is set, the selection equals `lock_port`, whatever the other port requests.
  - `lock` clears on the accepting cycle.
  - Selection never changes while a presented request is pending.
- **Full gating.**
  - While the FIFO count equals `OUTSTANDING`, `core_wr_o` and `core_rd_o` are forced to 0 and no accept is forwarded.
  - A pop in the same cycle does not release the gate; it releases one cycle later.
  - `lock` is unaffected by full gating.
- **Core drive.**
  - `core_*` equals the selected port's fields, gated as above.
  - When no port requests, `core_wr_o` = 0 and `core_rd_o` = 0. Address and data are don't-care.
- **Accept.**
  - `portX_accept_o` = `core_accept_i` & (core request active) & (X selected).
  - On accept: push X into the FIFO and set `last` = X.
- **Response routing.**
  - On `core_ack_i`: pop the FIFO head H.
  - `portH_ack_o` = 1, `portH_error_o` = `core_error_i`, `portH_read_data_o` = `core_read_data_i`.
  - The other port's ack and error are 0.
  - Both ports' `read_data_o` always carry `core_read_data_i`.
- **Stray ack.** `core_ack_i` with an empty FIFO is dropped: no port ack and no pop.
- **Simultaneous push and pop** when not full: count is unchanged, and the head and tail advance.
- **Count width** is clog2(`OUTSTANDING`)+1. Read and write pointers are clog2(`OUTSTANDING`) bits and wrap modulo `OUTSTANDING`.

## Timing
- The request path is combinational: zero cycles from port to core and from `core_accept_i` to `portX_accept_o`.
- The response path is combinational from `core_ack_i` to `portX_ack_o`. A response is never delayed or reordered.
- FIFO, `last`, `lock` and `lock_port` update on the rising edge of `ACLK`.
- **Reset.** `ARSTN` low clears count, pointers, `lock` (0) and `lock_port` (0) immediately, and sets `last` = 1. Asynchronous assert, synchronous-safe deassert by the system.
- **Outputs during reset.**
  - `core_wr_o` = 0, `core_rd_o` = 0.
  - All `accept`, `ack` and `error` outputs = 0, with the ack outputs masked while `ARSTN` is low.
  - All data outputs follow their sources.
- **Reset mid-burst.** Outstanding tags are discarded. Later core acks hit an empty FIFO and are dropped.
- Throughput is one accept per cycle, alternating under contention.

## Test plan
- **Solo read.** A reads 0x100 and the core accepts in the same cycle. Required: `portA_accept_o` = 1 that cycle. An ack 3 cycles later with data 0xDEADBEEF produces `portA_ack_o` = 1 and `portA_read_data_o` = 0xDEADBEEF, and `portB_ack_o` stays 0.
- **Contention, core always accepting.** A and B request continuously. Required: accepts follow A, B, A, B. Four acks return in that same A, B, A, B order.
- **Lock.** B is presented, then A arrives while `core_accept_i` is held 0 for 5 cycles. Required: `core_addr_o` stays at B's address for all 5 cycles, and B is accepted before A.
- **Full.** `OUTSTANDING` = 4, four accepts with no acks, A then requests. Required: `core_rd_o` = 0 until one cycle after the first `core_ack_i`. The fifth request is then accepted.
- **Error and stray ack.**
  - Ack with `core_error_i` = 1 for a B write. Required: `portB_error_o` = 1.
  - `core_ack_i` pulse with an empty FIFO. Required: no port ack.
- **Reset mid-operation.** Assert `ARSTN` low with 2 requests outstanding. Required: outputs go to 0 asynchronously. After release, the next 2 acks are dropped, and A wins the first contended grant.
